// File: rtl/bitset_sequencer.sv
// bitset_sequencer: multi-cycle controller around the single-bit-set datapath.
// A command loads a base word and then accepts a stream of bit indices over a
// valid/ready handshake. Each accepted in-range index ORs one bit into an
// accumulator. The final word is returned with a sticky error flag and a count
// of the indices that were applied.
//
// Optional feature, selected by the macro BITSEQ_TIMEOUT_EN:
//   defined   - an idle-cycle counter runs in ACCUM. After TIMEOUT consecutive
//               cycles with no beat, the command ends with the error flag set
//               and the partial word is returned.
//   undefined - ACCUM waits indefinitely for the last beat.
// The port list is the same in both builds.

module bitset_sequencer #(
  parameter int BITS    = 32,
  parameter int MAXIDX  = 32,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(MAXIDX + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_argA,
  input  logic            i_idx_valid,
  output logic            o_idx_ready,
  input  logic [BITS-1:0] i_idx,
  input  logic            i_idx_last,
  output logic            o_valid,
  input  logic            i_result_ready,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic [CW-1:0]   o_count,
  output logic            o_busy
);

  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [BITS-1:0] LAST_IDX = BITS'(BITS - 1);
  localparam logic [BITS-1:0] ONE_W    = BITS'(1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAXIDX);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  // Reject parameter sets the datapath cannot represent.
  if (BITS < 2 || MAXIDX < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("bitset_sequencer: BITS must be >= 2, MAXIDX and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, valid_q, busy_q;

  logic            beat_s;
  logic            idx_in_range_s;
  logic [BITS-1:0] bit_s;

`ifdef BITSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // ready_q is high exactly when the state register holds ACCUM.
  assign beat_s         = i_idx_valid & ready_q;
  assign idx_in_range_s = (i_idx <= LAST_IDX);
  assign bit_s          = ONE_W << i_idx[IW-1:0];

  // Next-state and datapath update for the command sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef BITSEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          acc_d   = i_argA;
          err_d   = 1'b0;
          cnt_d   = {CW{1'b0}};
`ifdef BITSEQ_TIMEOUT_EN
          tmo_d   = {TW{1'b0}};
`endif
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (beat_s) begin
          // An out-of-range index wins over saturation; either way acc and
          // cnt are left alone. A duplicate bit is still a counted beat.
          if (!idx_in_range_s) begin
            err_d = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            acc_d = acc_q | bit_s;
            cnt_d = cnt_q + CNT_ONE;
          end
`ifdef BITSEQ_TIMEOUT_EN
          tmo_d = {TW{1'b0}};
`endif
          if (i_idx_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
`ifdef BITSEQ_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmo_d   = tmo_q + TMO_ONE;
            state_d = ST_ACCUM;
          end
`else
          state_d = ST_ACCUM;
`endif
        end
      end
      ST_DONE: begin
        if (i_result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake flags; reset aborts any command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= {BITS{1'b0}};
      err_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BITSEQ_TIMEOUT_EN
      tmo_q   <= {TW{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_ACCUM);
      valid_q <= (state_d == ST_DONE);
      busy_q  <= (state_d == ST_ACCUM) || (state_d == ST_DONE);
`ifdef BITSEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign o_idx_ready = ready_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_result    = acc_q;
  assign o_error     = err_q;
  assign o_count     = cnt_q;

endmodule

// File: tb/tb_bitset_sequencer.sv
// Self-checking bench for bitset_sequencer (BITS=32, MAXIDX=32).
// Directed scenarios plus randomized commands compared against a
// transaction-level reference model.

module tb_bitset_sequencer;

  localparam int BITS   = 32;
  localparam int MAXIDX = 32;
  localparam int CW     = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] arga = '0;
  logic            idx_valid = 1'b0;
  logic            idx_ready;
  logic [BITS-1:0] idx = '0;
  logic            idx_last = 1'b0;
  logic            valid;
  logic            result_ready = 1'b0;
  logic [BITS-1:0] result;
  logic            error;
  logic [CW-1:0]   count;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  bitset_sequencer #(.BITS(BITS), .MAXIDX(MAXIDX), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_argA(arga),
    .i_idx_valid(idx_valid), .o_idx_ready(idx_ready), .i_idx(idx),
    .i_idx_last(idx_last), .o_valid(valid), .i_result_ready(result_ready),
    .o_result(result), .o_error(error), .o_count(count), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: apply the index list to the base word by the command rules.
  task automatic model_cmd(input logic [31:0] a, input logic [31:0] q[$],
                           output logic [31:0] r, output logic e, output int c);
    r = a; e = 1'b0; c = 0;
    foreach (q[i]) begin
      if (q[i] > 32'd31) e = 1'b1;
      else if (c == MAXIDX) e = 1'b1;
      else begin
        r = r | (32'd1 << q[i]);
        c = c + 1;
      end
    end
  endtask

  // Drive one complete command; report what the DUT produced.
  task automatic do_cmd(input logic [31:0] a, input logic [31:0] q[$],
                        input int stall, input int max_gap,
                        output logic [31:0] r, output logic e, output logic [CW-1:0] c,
                        output logic on_time, output logic stable, output logic idle_after);
    start = 1'b1; arga = a;
    tick();
    start = 1'b0;
    on_time = 1'b1;
    foreach (q[k]) begin
      repeat ($urandom_range(0, max_gap)) begin
        tick();
        if (valid) on_time = 1'b0;
      end
      if (!idx_ready) on_time = 1'b0;
      idx_valid = 1'b1; idx = q[k]; idx_last = (k == q.size() - 1);
      tick();
      idx_valid = 1'b0; idx_last = 1'b0;
      if (k != q.size() - 1 && valid) on_time = 1'b0;
    end
    if (!valid || idx_ready) on_time = 1'b0;
    r = result; e = error; c = count;
    stable = 1'b1;
    repeat (stall) begin
      tick();
      if (!valid || result !== r || error !== e || count !== c) stable = 1'b0;
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    idle_after = !valid && !busy && !idx_ready && (result === r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({valid, idx_ready, busy, error, count, result} !== '0) begin
      n_fail++;
      $display("FAIL reset: got valid=%b rdy=%b busy=%b err=%b cnt=%0d res=%h, want all zero",
               valid, idx_ready, busy, error, count, result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_t1_basic(input int stall, input string nm);
    logic [31:0] q[$];
    logic [31:0] r; logic e; logic [CW-1:0] c; logic ot, st, ia;
    q = '{32'd0, 32'd5, 32'd31};
    do_cmd(32'h0, q, stall, 0, r, e, c, ot, st, ia);
    n_checks++;
    if (r !== 32'h8000_0021 || e !== 1'b0 || c !== 6'd3) begin
      n_fail++;
      $display("FAIL %s result: got %h/%b/%0d want 80000021/0/3", nm, r, e, c);
    end
    n_checks++;
    if (ot !== 1'b1) begin
      n_fail++; $display("FAIL %s latency: got %b want 1", nm, ot);
    end
    n_checks++;
    if (st !== 1'b1 || ia !== 1'b1) begin
      n_fail++; $display("FAIL %s hold/idle: got stable=%b idle=%b want 1/1", nm, st, ia);
    end
  endtask

  task automatic test_t2_errors();
    logic [31:0] q[$];
    logic [31:0] r; logic e; logic [CW-1:0] c; logic ot, st, ia;
    q = '{32'd32, 32'hFFFF_FFFF, 32'd4};
    do_cmd(32'h0000_00F0, q, 0, 1, r, e, c, ot, st, ia);
    n_checks++;
    if (r !== 32'h0000_00F0 || e !== 1'b1 || c !== 6'd1) begin
      n_fail++;
      $display("FAIL t2 errors: got %h/%b/%0d want 000000f0/1/1", r, e, c);
    end
  endtask

  task automatic test_duplicate();
    logic [31:0] q[$];
    logic [31:0] r; logic e; logic [CW-1:0] c; logic ot, st, ia;
    q = '{32'd0, 32'd0};
    do_cmd(32'h1, q, 0, 0, r, e, c, ot, st, ia);
    n_checks++;
    if (r !== 32'h1 || e !== 1'b0 || c !== 6'd2) begin
      n_fail++;
      $display("FAIL duplicate: got %h/%b/%0d want 00000001/0/2", r, e, c);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] q[$];
    logic [31:0] r; logic e; logic [CW-1:0] c; logic ot, st, ia;
    q = {};
    for (int i = 0; i < MAXIDX; i++) q.push_back(32'd0);
    q.push_back(32'd7);
    q.push_back(32'd9);
    do_cmd(32'h0, q, 0, 0, r, e, c, ot, st, ia);
    n_checks++;
    if (r !== 32'h1 || e !== 1'b1 || c !== 6'd32) begin
      n_fail++;
      $display("FAIL saturation: got %h/%b/%0d want 00000001/1/32", r, e, c);
    end
  endtask

  task automatic test_t4_start_ignored();
    start = 1'b1; arga = 32'h1;
    tick();
    arga = 32'hFFFF_0000;
    idx_valid = 1'b1; idx = 32'd2; idx_last = 1'b0;
    tick();
    n_checks++;
    if (result !== 32'h5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL t4 accum: got res=%h busy=%b want 00000005/1", result, busy);
    end
    idx = 32'd3; idx_last = 1'b1;
    tick();
    idx = 32'd20; idx_last = 1'b0;
    tick();
    n_checks++;
    if (valid !== 1'b1 || result !== 32'hD || count !== 6'd2) begin
      n_fail++;
      $display("FAIL t4 done: got v=%b res=%h cnt=%0d want 1/0000000d/2", valid, result, count);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'hD) begin
      n_fail++;
      $display("FAIL t4 idle: got busy=%b v=%b res=%h want 0/0/0000000d", busy, valid, result);
    end
    tick();
    idx_valid = 1'b0;
    n_checks++;
    if (idx_ready !== 1'b0 || result !== 32'hD || count !== 6'd2) begin
      n_fail++;
      $display("FAIL t4 idle hold: got rdy=%b res=%h cnt=%0d want 0/0000000d/2",
               idx_ready, result, count);
    end
  endtask

  task automatic test_t5_reset_abort();
    logic saw_valid;
    start = 1'b1; arga = 32'h5;
    tick();
    start = 1'b0;
    idx_valid = 1'b1; idx = 32'd8;
    tick();
    idx = 32'd9;
    tick();
    idx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({valid, idx_ready, busy, error, count, result} !== '0) begin
      n_fail++;
      $display("FAIL t5 abort: got v=%b rdy=%b busy=%b err=%b cnt=%0d res=%h want all zero",
               valid, idx_ready, busy, error, count, result);
    end
    saw_valid = 1'b0;
    repeat (3) begin
      tick();
      if (valid || busy) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++; $display("FAIL t5 no result: got %b want 0", saw_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] a, r, er; logic e, ee; logic [CW-1:0] c; int ec;
    logic ot, st, ia;
    for (int t = 0; t < 25; t++) begin
      a = $urandom;
      q = {};
      for (int k = 0; k < $urandom_range(1, 8); k++) begin
        case ($urandom_range(0, 9))
          0: q.push_back(32'd32 + $urandom_range(0, 200));
          1: q.push_back(32'h8000_0000 | $urandom);
          default: q.push_back($urandom_range(0, 31));
        endcase
      end
      model_cmd(a, q, er, ee, ec);
      do_cmd(a, q, $urandom_range(0, 3), 2, r, e, c, ot, st, ia);
      n_checks++;
      if (r !== er || e !== ee || c !== CW'(ec) || ot !== 1'b1 || st !== 1'b1 || ia !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h/%b/%0d t=%b s=%b i=%b want %h/%b/%0d t=1 s=1 i=1",
                 t, r, e, c, ot, st, ia, er, ee, ec);
      end
    end
  endtask

`ifdef BITSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    start = 1'b1; arga = 32'h100;
    tick();
    start = 1'b0;
    idx_valid = 1'b1; idx = 32'd3;
    tick();
    idx_valid = 1'b0;
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid) begin waited = i; break; end
    end
    n_checks++;
    if (waited !== 16 || result !== 32'h108 || error !== 1'b1 || count !== 6'd1) begin
      n_fail++;
      $display("FAIL timeout: got wait=%0d res=%h err=%b cnt=%0d want 16/00000108/1/1",
               waited, result, error, count);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_t1_basic(0, "t1");
    test_t2_errors();
    test_t1_basic(5, "t3");
    test_duplicate();
    test_saturation();
    test_t4_start_ignored();
    test_t5_reset_abort();
    test_random();
`ifdef BITSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
